mem_port_arbiter: RTL and testbench

- Shares the single unified RAM port between the multi-cycle CPU memory interface and a debug/dump master (memory dump and initial program load).
- Round-robin arbitration with a req/ack handshake.
- Fixed-latency access sequencing and address-window checking.
- Sits between the CPU/debug masters and the RAM in Top.

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between the CPU and a debug/dump master.
// Fixed-latency access sequencing with an address window check; all outputs registered.
//
// state    | meaning
// S_IDLE   | waiting for a request; arbitration happens here
// S_ACCESS | RAM enable held for MEM_LAT cycles with latched address/data
// S_RESP   | one-cycle ack to the owner with rdata/err valid
module mem_port_arbiter #(
    parameter int unsigned       ADDR_W  = 32,
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       MEM_LAT = 1,
    parameter logic [ADDR_W-1:0] ADDR_LO = ADDR_W'(32'h0040_0000),
    parameter logic [ADDR_W-1:0] ADDR_HI = ADDR_W'(32'h0052_0000)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [3:0] LAT_M1  = 4'(MEM_LAT - 1);
    localparam logic       OWN_DBG = 1'b1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_last_owner, w_last_nxt;
    logic              r_owner, w_owner_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_mem_en, w_mem_en_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_cpu_ack, w_cpu_ack_nxt;
    logic              r_cpu_err, w_cpu_err_nxt;
    logic [DATA_W-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
    logic              r_dbg_ack, w_dbg_ack_nxt;
    logic              r_dbg_err, w_dbg_err_nxt;
    logic [DATA_W-1:0] r_dbg_rdata, w_dbg_rdata_nxt;

    logic              w_grant_vld;
    logic              w_grant_sel;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_in_win;

    // On a tie the master that did not win last time gets the port.
    assign w_grant_vld = cpu_req | dbg_req;
    assign w_grant_sel = (cpu_req & dbg_req) ? ~r_last_owner : dbg_req;
    assign w_sel_we    = w_grant_sel ? dbg_we    : cpu_we;
    assign w_sel_addr  = w_grant_sel ? dbg_addr  : cpu_addr;
    assign w_sel_wdata = w_grant_sel ? dbg_wdata : cpu_wdata;
    assign w_in_win    = (w_sel_addr >= ADDR_LO) && (w_sel_addr <= ADDR_HI);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_owner <= OWN_DBG;
            r_owner      <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_cpu_err    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dbg_ack    <= 1'b0;
            r_dbg_err    <= 1'b0;
            r_dbg_rdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_owner <= w_last_nxt;
            r_owner      <= w_owner_nxt;
            r_busy       <= w_busy_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_cpu_ack    <= w_cpu_ack_nxt;
            r_cpu_err    <= w_cpu_err_nxt;
            r_cpu_rdata  <= w_cpu_rdata_nxt;
            r_dbg_ack    <= w_dbg_ack_nxt;
            r_dbg_err    <= w_dbg_err_nxt;
            r_dbg_rdata  <= w_dbg_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_vld) w_state_nxt = w_in_win ? S_ACCESS : S_RESP;
            S_ACCESS: if (r_cnt == '0) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for every registered output; anything not driven below returns to 0.
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last_owner;
        w_owner_nxt     = r_owner;
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        w_cpu_ack_nxt   = 1'b0;
        w_cpu_err_nxt   = 1'b0;
        w_cpu_rdata_nxt = '0;
        w_dbg_ack_nxt   = 1'b0;
        w_dbg_err_nxt   = 1'b0;
        w_dbg_rdata_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_owner_nxt = w_grant_sel;
                    w_last_nxt  = w_grant_sel;
                    if (w_in_win) begin
                        w_mem_en_nxt    = 1'b1;
                        w_mem_we_nxt    = w_sel_we;
                        w_mem_addr_nxt  = w_sel_addr;
                        w_mem_wdata_nxt = w_sel_wdata;
                        w_cnt_nxt       = LAT_M1;
                    end else if (w_grant_sel) begin
                        w_dbg_ack_nxt = 1'b1;
                        w_dbg_err_nxt = 1'b1;
                    end else begin
                        w_cpu_ack_nxt = 1'b1;
                        w_cpu_err_nxt = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt       = r_cnt - 4'd1;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = r_mem_we;
                    w_mem_addr_nxt  = r_mem_addr;
                    w_mem_wdata_nxt = r_mem_wdata;
                end else if (r_owner) begin
                    w_dbg_ack_nxt   = 1'b1;
                    w_dbg_rdata_nxt = r_mem_we ? '0 : mem_rdata;
                end else begin
                    w_cpu_ack_nxt   = 1'b1;
                    w_cpu_rdata_nxt = r_mem_we ? '0 : mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_err   = r_cpu_err;
    assign dbg_rdata = r_dbg_rdata;
    assign dbg_ack   = r_dbg_ack;
    assign dbg_err   = r_dbg_err;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected acks and RAM accesses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;
    localparam int          LAT = 2;
    localparam int          P   = LAT + 2;
    localparam logic [31:0] LO  = 32'h0040_0000;
    localparam logic [31:0] HI  = 32'h0052_0000;
    localparam logic [31:0] KEY = 32'h2050_0005;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_ack, cpu_err;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0, dbg_rdata;
    logic        dbg_ack, dbg_err;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, owner;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .ADDR_LO(LO), .ADDR_HI(HI)
    ) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    // RAM stand-in: read data is a fixed scramble of the address (0x0040_0000 -> 0x2010_0005).
    assign mem_rdata = mem_addr ^ KEY;

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic [31:0] rdata; logic err; int lbl; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int lbl; } mreq_t;
    resp_t cq[$];
    resp_t dq[$];
    mreq_t cmq[$];
    mreq_t dmq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"},    64'(mem_en),    64'(0));
        chk({tag, "_mem_we"},    64'(mem_we),    64'(0));
        chk({tag, "_mem_addr"},  64'(mem_addr),  64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_busy"},      64'(busy),      64'(0));
        chk({tag, "_owner"},     64'(owner),     64'(0));
        chk({tag, "_cpu_resp"},  64'({cpu_ack, cpu_err, cpu_rdata}), 64'(0));
        chk({tag, "_dbg_resp"},  64'({dbg_ack, dbg_err, dbg_rdata}), 64'(0));
    endtask

    task automatic chk_ack(input bit m, input logic [31:0] rd, input logic er);
        resp_t e;
        if ((m && dq.size() == 0) || (!m && cq.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_ack_unexpected: ack seen with nothing outstanding (t=%0t)",
                     m ? "dbg" : "cpu", $time);
        end else begin
            if (m) e = dq.pop_front();
            else   e = cq.pop_front();
            chk(m ? "dbg_rdata" : "cpu_rdata", 64'(rd), 64'(e.rdata));
            chk(m ? "dbg_err" : "cpu_err", 64'(er), 64'(e.err));
            chk(m ? "dbg_ack_cycle" : "cpu_ack_cycle", 64'(cyc + 1), 64'(e.lbl));
            chk(m ? "dbg_ack_owner" : "cpu_ack_owner", 64'(owner), 64'(m));
            chk("ack_busy", 64'(busy), 64'(1));
        end
    endtask

    bit    in_run = 1'b0;
    int    run_len = 0;
    mreq_t cur;

    // Monitor: spec cycle label of the current period is cyc+1 at the negedge.
    always @(negedge CLK) begin
        if (RST) begin
            in_run = 1'b0;
        end else begin
            if (cpu_ack) chk_ack(1'b0, cpu_rdata, cpu_err);
            else         chk("cpu_idle_resp", 64'({cpu_err, cpu_rdata}), 64'(0));
            if (dbg_ack) chk_ack(1'b1, dbg_rdata, dbg_err);
            else         chk("dbg_idle_resp", 64'({dbg_err, dbg_rdata}), 64'(0));
            if (mem_en) begin
                if (!in_run) begin
                    in_run  = 1'b1;
                    run_len = 1;
                    if ((owner && dmq.size() == 0) || (!owner && cmq.size() == 0)) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL mem_en_unexpected: access at 0x%0h with nothing queued (t=%0t)",
                                 mem_addr, $time);
                        cur = '{we: 1'b0, addr: 32'hFFFF_FFFF, wdata: 32'h0, lbl: 0};
                    end else begin
                        if (owner) cur = dmq.pop_front();
                        else       cur = cmq.pop_front();
                        chk("mem_addr",     64'(mem_addr),  64'(cur.addr));
                        chk("mem_we",       64'(mem_we),    64'(cur.we));
                        chk("mem_wdata",    64'(mem_wdata), 64'(cur.wdata));
                        chk("mem_en_cycle", 64'(cyc + 1),   64'(cur.lbl));
                    end
                end else begin
                    run_len++;
                    chk("mem_addr_hold", 64'(mem_addr), 64'(cur.addr));
                    chk("mem_we_hold",   64'(mem_we),   64'(cur.we));
                end
            end else begin
                chk("mem_we_without_en", 64'(mem_we), 64'(0));
                if (in_run) begin
                    in_run = 1'b0;
                    chk("mem_en_len", 64'(run_len), 64'(LAT));
                end
            end
        end
    end

    // Call at a negedge. grant_edge < 0 means the DUT is idle and grants at the next edge.
    task automatic do_txn(input bit m, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int grant_edge, input bit chg);
        int          n;
        int          k;
        bit          in_win;
        bit          got;
        logic [31:0] exp_rd;
        n      = (grant_edge < 0) ? cyc + 1 : grant_edge;
        in_win = (addr >= LO) && (addr <= HI);
        exp_rd = (!in_win || we) ? 32'h0 : (addr ^ KEY);
        if (m) dq.push_back('{rdata: exp_rd, err: !in_win, lbl: in_win ? n + LAT + 1 : n + 1});
        else   cq.push_back('{rdata: exp_rd, err: !in_win, lbl: in_win ? n + LAT + 1 : n + 1});
        if (in_win) begin
            if (m) dmq.push_back('{we: we, addr: addr, wdata: wdata, lbl: n + 1});
            else   cmq.push_back('{we: we, addr: addr, wdata: wdata, lbl: n + 1});
        end
        if (m) begin dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1; end
        else   begin cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1; end
        k   = 0;
        got = 1'b0;
        while (!got && k < 100) begin
            @(negedge CLK);
            k++;
            if (chg && k == 1) begin
                if (m) dbg_addr = addr + 32'h10;
                else   cpu_addr = addr + 32'h10;
            end
            got = m ? dbg_ack : cpu_ack;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_ack_timeout: no ack within 100 cycles for addr 0x%0h", m ? "dbg" : "cpu", addr);
        end
        if (m) dbg_req = 1'b0;
        else   cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int n0;
        repeat (2) @(negedge CLK);
        chk_all_zero("por");
        RST = 1'b0;
        @(negedge CLK);

        // Contention right after reset: CPU first, then strict alternation every P cycles.
        n0 = cyc + 1;
        fork
            begin
                do_txn(1'b0, 1'b1, 32'h0040_0100, 32'h1111_0001, n0, 1'b0);
                do_txn(1'b0, 1'b0, 32'h0040_0104, 32'h0,         n0 + 2 * P, 1'b0);
                do_txn(1'b0, 1'b0, 32'h0040_0108, 32'h0,         n0 + 4 * P, 1'b0);
            end
            begin
                do_txn(1'b1, 1'b0, 32'h0050_0000, 32'h0,         n0 + P, 1'b0);
                do_txn(1'b1, 1'b1, 32'h0050_0004, 32'h2222_0002, n0 + 3 * P, 1'b0);
                do_txn(1'b1, 1'b0, 32'h0050_0008, 32'h0,         n0 + 5 * P, 1'b0);
            end
        join
        @(negedge CLK);

        do_txn(1'b0, 1'b0, LO, 32'h0, -1, 1'b0);
        @(negedge CLK);
        do_txn(1'b1, 1'b1, HI, 32'hDEAD_BEEF, -1, 1'b0);
        @(negedge CLK);
        do_txn(1'b1, 1'b0, HI + 32'h1, 32'h0, -1, 1'b0);
        @(negedge CLK);
        do_txn(1'b0, 1'b1, LO - 32'h1, 32'h3333_0003, -1, 1'b0);
        @(negedge CLK);
        do_txn(1'b0, 1'b0, HI, 32'h0, -1, 1'b0);
        @(negedge CLK);
        do_txn(1'b1, 1'b0, LO + 32'h4, 32'h0, -1, 1'b0);
        @(negedge CLK);
        do_txn(1'b0, 1'b0, 32'h0040_0010, 32'h0, -1, 1'b1);
        @(negedge CLK);

        // Reset on the second access cycle of a CPU write: no ack, reissue completes.
        cmq.push_back('{we: 1'b1, addr: 32'h0040_0200, wdata: 32'hA5A5_5A5A, lbl: cyc + 2});
        cpu_we = 1'b1; cpu_addr = 32'h0040_0200; cpu_wdata = 32'hA5A5_5A5A; cpu_req = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b1;
        cpu_req = 1'b0;
        #1 chk_all_zero("rst_mid_access");
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        do_txn(1'b0, 1'b1, 32'h0040_0200, 32'hA5A5_5A5A, -1, 1'b0);

        repeat (4) @(negedge CLK);
        chk("cpu_resp_left", 64'(cq.size()),  64'(0));
        chk("dbg_resp_left", 64'(dq.size()),  64'(0));
        chk("cpu_mem_left",  64'(cmq.size()), 64'(0));
        chk("dbg_mem_left",  64'(dmq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
